// File: rtl/sata_ll_pkg.sv
// Shared SATA link-layer definitions: TX FIFO word layout, frame reader
// state encoding and default frame-length limits.
package sata_ll_pkg;

    localparam int TXLL_EOF_BIT    = 34;
    localparam int TXLL_DATA_MSB   = 31;
    localparam int C_MAX_DWORDS_DEF = 2064;
    localparam int C_CNT_WIDTH_DEF  = 12;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_XMIT  = 3'd2,
        ST_LAST  = 3'd3,
        ST_DRAIN = 3'd4
    } txll_state_e;

endpackage

// File: rtl/txll_frame_reader.sv
// Read side of the TX link-layer FIFO: waits for a whole buffered frame,
// requests the link, streams dwords out and drains aborted/over-length frames.
module txll_frame_reader
    import sata_ll_pkg::*;
#(
    parameter int C_MAX_DWORDS = C_MAX_DWORDS_DEF,
    parameter int C_CNT_WIDTH  = C_CNT_WIDTH_DEF
) (
    input  logic                   rd_clk,
    input  logic                   rst,
    input  logic [35:0]            fifo_do,
    input  logic                   fifo_empty,
    input  logic                   fifo_eof_rdy,
    output logic                   fifo_rd_en,
    output logic                   ll_frame_req,
    input  logic                   ll_frame_go,
    input  logic                   ll_abort,
    output logic [31:0]            ll_data,
    output logic                   ll_sof,
    output logic                   ll_eof,
    output logic                   ll_valid,
    input  logic                   ll_ready,
    output logic                   frame_done,
    output logic                   frame_aborted,
    output logic                   len_err,
    output logic [C_CNT_WIDTH-1:0] dword_cnt
);

    localparam logic [C_CNT_WIDTH-1:0] MAX_CNT = C_MAX_DWORDS[C_CNT_WIDTH-1:0];
    localparam logic [C_CNT_WIDTH-1:0] CNT_ONE = {{(C_CNT_WIDTH-1){1'b0}}, 1'b1};

    txll_state_e            state_q, state_d;
    logic [31:0]            ll_data_q, ll_data_d;
    logic                   ll_sof_q, ll_sof_d;
    logic                   ll_eof_q, ll_eof_d;
    logic                   ll_valid_q, ll_valid_d;
    logic                   ll_frame_req_q, ll_frame_req_d;
    logic                   frame_done_q, frame_done_d;
    logic                   frame_aborted_q, frame_aborted_d;
    logic                   len_err_q, len_err_d;
    logic [C_CNT_WIDTH-1:0] dword_cnt_q, dword_cnt_d;
    logic                   first_q, first_d;
    logic                   rd_en;

    logic                   load;
    logic                   accept;
    logic                   word_eof;
    logic [31:0]            word_data;
    logic [C_CNT_WIDTH-1:0] cnt_inc;
    logic                   unused_fifo_bits;

    assign word_eof  = fifo_do[TXLL_EOF_BIT];
    assign word_data = fifo_do[TXLL_DATA_MSB:0];
    assign unused_fifo_bits = ^{fifo_do[35], fifo_do[33:32]};

    // Output handshake: a dword moves to the link on any cycle where
    // ll_valid and ll_ready are both high; the register may reload that same cycle.
    assign accept  = ll_valid_q & ll_ready;
    assign load    = (state_q == ST_XMIT) & ~fifo_empty & (~ll_valid_q | ll_ready);
    assign cnt_inc = (dword_cnt_q == MAX_CNT) ? dword_cnt_q : dword_cnt_q + CNT_ONE;

    always_comb begin
        state_d         = state_q;
        ll_data_d       = ll_data_q;
        ll_sof_d        = ll_sof_q;
        ll_eof_d        = ll_eof_q;
        ll_valid_d      = ll_valid_q;
        ll_frame_req_d  = ll_frame_req_q;
        frame_done_d    = 1'b0;
        frame_aborted_d = 1'b0;
        len_err_d       = 1'b0;
        dword_cnt_d     = dword_cnt_q;
        first_d         = first_q;
        rd_en           = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (fifo_eof_rdy && !fifo_empty) begin
                    state_d        = ST_REQ;
                    ll_frame_req_d = 1'b1;
                    dword_cnt_d    = '0;
                    first_d        = 1'b1;
                end
            end

            ST_REQ: begin
                if (ll_abort) begin
                    state_d         = ST_IDLE;
                    ll_frame_req_d  = 1'b0;
                    frame_aborted_d = 1'b1;
                end else if (ll_frame_go) begin
                    state_d = ST_XMIT;
                end
            end

            ST_XMIT: begin
                rd_en = load;
                if (load) begin
                    dword_cnt_d = cnt_inc;
                    len_err_d   = !word_eof && (cnt_inc == MAX_CNT);
                end
                if (ll_abort) begin
                    // The EOF may be consumed in the abort cycle; nothing left to drain then.
                    ll_valid_d     = 1'b0;
                    ll_frame_req_d = 1'b0;
                    if (load && word_eof) begin
                        state_d         = ST_IDLE;
                        frame_aborted_d = 1'b1;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end else if (load) begin
                    ll_data_d  = word_data;
                    ll_sof_d   = first_q;
                    ll_eof_d   = word_eof;
                    ll_valid_d = 1'b1;
                    first_d    = 1'b0;
                    if (word_eof) begin
                        state_d = ST_LAST;
                    end else if (cnt_inc == MAX_CNT) begin
                        state_d        = ST_DRAIN;
                        ll_valid_d     = 1'b0;
                        ll_frame_req_d = 1'b0;
                    end
                end else if (accept) begin
                    ll_valid_d = 1'b0;
                end
            end

            ST_LAST: begin
                if (accept) begin
                    state_d        = ST_IDLE;
                    ll_valid_d     = 1'b0;
                    ll_frame_req_d = 1'b0;
                    frame_done_d   = 1'b1;
                end else if (ll_abort) begin
                    state_d         = ST_IDLE;
                    ll_valid_d      = 1'b0;
                    ll_frame_req_d  = 1'b0;
                    frame_aborted_d = 1'b1;
                end
            end

            ST_DRAIN: begin
                rd_en = !fifo_empty;
                if (!fifo_empty) begin
                    dword_cnt_d = cnt_inc;
                    if (word_eof) begin
                        state_d         = ST_IDLE;
                        frame_aborted_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d        = ST_IDLE;
                ll_valid_d     = 1'b0;
                ll_frame_req_d = 1'b0;
            end
        endcase

        if (!ll_valid_d) begin
            ll_data_d = '0;
            ll_sof_d  = 1'b0;
            ll_eof_d  = 1'b0;
        end
    end

    always_ff @(posedge rd_clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            ll_data_q       <= '0;
            ll_sof_q        <= 1'b0;
            ll_eof_q        <= 1'b0;
            ll_valid_q      <= 1'b0;
            ll_frame_req_q  <= 1'b0;
            frame_done_q    <= 1'b0;
            frame_aborted_q <= 1'b0;
            len_err_q       <= 1'b0;
            dword_cnt_q     <= '0;
            first_q         <= 1'b0;
        end else begin
            state_q         <= state_d;
            ll_data_q       <= ll_data_d;
            ll_sof_q        <= ll_sof_d;
            ll_eof_q        <= ll_eof_d;
            ll_valid_q      <= ll_valid_d;
            ll_frame_req_q  <= ll_frame_req_d;
            frame_done_q    <= frame_done_d;
            frame_aborted_q <= frame_aborted_d;
            len_err_q       <= len_err_d;
            dword_cnt_q     <= dword_cnt_d;
            first_q         <= first_d;
        end
    end

    // Reset must never pop: the FIFO keeps its contents across a reader reset.
    assign fifo_rd_en    = rd_en & ~rst;
    assign ll_frame_req  = ll_frame_req_q;
    assign ll_data       = ll_data_q;
    assign ll_sof        = ll_sof_q;
    assign ll_eof        = ll_eof_q;
    assign ll_valid      = ll_valid_q;
    assign frame_done    = frame_done_q;
    assign frame_aborted = frame_aborted_q;
    assign len_err       = len_err_q;
    assign dword_cnt     = dword_cnt_q;

endmodule

// File: tb/tb_txll_frame_reader.sv
// Bench for txll_frame_reader: FWFT FIFO model, cycle table for a basic frame,
// hand sequences for backpressure, aborts, length error and reset.
module tb_txll_frame_reader;
  import sata_ll_pkg::*;

  localparam int MAXD = 2064;
  localparam int CW   = 12;

  logic          rd_clk = 1'b0;
  logic          rst;
  logic [35:0]   fifo_do;
  logic          fifo_empty;
  logic          fifo_eof_rdy;
  logic          fifo_rd_en;
  logic          ll_frame_req;
  logic          ll_frame_go;
  logic          ll_abort;
  logic [31:0]   ll_data;
  logic          ll_sof;
  logic          ll_eof;
  logic          ll_valid;
  logic          ll_ready;
  logic          frame_done;
  logic          frame_aborted;
  logic          len_err;
  logic [CW-1:0] dword_cnt;

  txll_frame_reader #(.C_MAX_DWORDS(MAXD), .C_CNT_WIDTH(CW)) dut (
    .rd_clk(rd_clk), .rst(rst),
    .fifo_do(fifo_do), .fifo_empty(fifo_empty), .fifo_eof_rdy(fifo_eof_rdy),
    .fifo_rd_en(fifo_rd_en),
    .ll_frame_req(ll_frame_req), .ll_frame_go(ll_frame_go), .ll_abort(ll_abort),
    .ll_data(ll_data), .ll_sof(ll_sof), .ll_eof(ll_eof), .ll_valid(ll_valid),
    .ll_ready(ll_ready),
    .frame_done(frame_done), .frame_aborted(frame_aborted), .len_err(len_err),
    .dword_cnt(dword_cnt)
  );

  // clock / reset
  always #5 rd_clk = ~rd_clk;

  logic [35:0] fifo_q[$];
  logic [33:0] exp_q[$];

  int errors = 0;
  int checks = 0;
  int pops = 0;
  int acc_cnt = 0;
  int done_cnt = 0;
  int abort_cnt = 0;
  int lerr_cnt = 0;
  int lerr_mark = 0;

  typedef struct {
    logic        go;
    logic        rdy;
    logic [37:0] exp_o;   // {req, valid, sof, eof, data, rd_en, done}
    logic [11:0] exp_cnt;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(input logic go, input logic rdy, input logic req,
                              input logic vld, input logic sof, input logic eof,
                              input logic [31:0] d, input logic rd, input logic done,
                              input logic [11:0] cnt);
    vec_t v;
    v.go = go;
    v.rdy = rdy;
    v.exp_o = {req, vld, sof, eof, d, rd, done};
    v.exp_cnt = cnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fifo_update();
    fifo_empty = (fifo_q.size() == 0);
    fifo_do = fifo_empty ? 36'h0 : fifo_q[0];
    fifo_eof_rdy = 1'b0;
    foreach (fifo_q[i]) if (fifo_q[i][34]) fifo_eof_rdy = 1'b1;
  endtask

  task automatic push_frame(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      logic [31:0] d;
      d = base + 32'(i);
      fifo_q.push_back({1'b0, (i == n - 1), 2'b00, d});
    end
    fifo_update();
  endtask

  task automatic push_exp(input int n, input logic [31:0] base, input int count);
    for (int i = 0; i < count; i++) begin
      logic [31:0] d;
      d = base + 32'(i);
      exp_q.push_back({(i == 0), (i == n - 1), d});
    end
  endtask

  // One clock: sample before the edge (scoreboard + counters), pop after it.
  task automatic tick();
    logic pop_now;
    logic [33:0] e;
    #2;
    pop_now = fifo_rd_en;
    if (ll_valid && !ll_ready) check("no_pop_while_stalled", 64'(fifo_rd_en), 64'd0);
    if (ll_valid && ll_ready) begin
      acc_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL beat: got unexpected dword %0h expected none", ll_data);
      end else begin
        e = exp_q.pop_front();
        check("beat", 64'({ll_sof, ll_eof, ll_data}), 64'(e));
      end
    end
    if (frame_done) done_cnt++;
    if (frame_aborted) abort_cnt++;
    if (len_err) begin
      lerr_cnt++;
      lerr_mark = pops;
    end
    if (pop_now) pops++;
    @(posedge rd_clk);
    #1;
    if (pop_now && fifo_q.size() > 0) void'(fifo_q.pop_front());
    fifo_update();
  endtask

  task automatic wait_state(input txll_state_e st, input int budget, input string name);
    int n;
    n = 0;
    while (dut.state_q != st && n < budget) begin
      tick();
      n++;
    end
    check(name, 64'(dut.state_q), 64'(st));
  endtask

  int p0, d0, a0, c0, l0;

  initial begin
    vecs[0]  = mk(0, 1, 0, 0, 0, 0, 32'h0,         0, 0, 12'd0);
    vecs[1]  = mk(0, 1, 1, 0, 0, 0, 32'h0,         0, 0, 12'd0);
    vecs[2]  = mk(0, 1, 1, 0, 0, 0, 32'h0,         0, 0, 12'd0);
    vecs[3]  = mk(0, 1, 1, 0, 0, 0, 32'h0,         0, 0, 12'd0);
    vecs[4]  = mk(1, 1, 1, 0, 0, 0, 32'h0,         0, 0, 12'd0);
    vecs[5]  = mk(0, 1, 1, 0, 0, 0, 32'h0,         1, 0, 12'd0);
    vecs[6]  = mk(0, 1, 1, 1, 1, 0, 32'hA000_0000, 1, 0, 12'd1);
    vecs[7]  = mk(1, 1, 1, 1, 0, 0, 32'hA000_0001, 1, 0, 12'd2);
    vecs[8]  = mk(0, 1, 1, 1, 0, 0, 32'hA000_0002, 1, 0, 12'd3);
    vecs[9]  = mk(0, 1, 1, 1, 0, 1, 32'hA000_0003, 0, 0, 12'd4);
    vecs[10] = mk(0, 1, 0, 0, 0, 0, 32'h0,         0, 1, 12'd4);
    vecs[11] = mk(0, 1, 0, 0, 0, 0, 32'h0,         0, 0, 12'd4);

    rst = 1'b1;
    ll_frame_go = 1'b0;
    ll_abort = 1'b0;
    ll_ready = 1'b1;
    fifo_update();
    repeat (3) tick();
    rst = 1'b0;
    check("reset_outputs",
          64'({ll_frame_req, ll_data, ll_sof, ll_eof, ll_valid, frame_done, frame_aborted, len_err}),
          64'd0);
    check("reset_cnt", 64'(dword_cnt), 64'd0);
    check("reset_state", 64'(dut.state_q), 64'(ST_IDLE));

    // 4-dword frame, grant three cycles after request, cycle by cycle
    push_frame(4, 32'hA000_0000);
    push_exp(4, 32'hA000_0000, 4);
    p0 = pops;
    for (int i = 0; i < 12; i++) begin
      ll_frame_go = vecs[i].go;
      ll_ready = vecs[i].rdy;
      #1;
      check($sformatf("vec%0d", i),
            64'({ll_frame_req, ll_valid, ll_sof, ll_eof, ll_data, fifo_rd_en, frame_done}),
            64'(vecs[i].exp_o));
      check($sformatf("vec%0d_cnt", i), 64'(dword_cnt), 64'(vecs[i].exp_cnt));
      tick();
    end
    check("basic_pops", 64'(pops - p0), 64'd4);
    check("basic_done", 64'(done_cnt), 64'd1);

    // backpressure: ready pattern 1,0,0,1
    push_frame(4, 32'hB000_0000);
    push_exp(4, 32'hB000_0000, 4);
    p0 = pops; d0 = done_cnt;
    ll_frame_go = 1'b1;
    for (int k = 0; k < 80 && done_cnt == d0; k++) begin
      ll_ready = (k % 4 == 0) || (k % 4 == 3);
      tick();
    end
    ll_ready = 1'b1;
    ll_frame_go = 1'b0;
    check("bp_done", 64'(done_cnt - d0), 64'd1);
    check("bp_pops", 64'(pops - p0), 64'd4);
    check("bp_all_beats", 64'(exp_q.size()), 64'd0);
    check("bp_cnt", 64'(dword_cnt), 64'd4);

    // abort after D1 accepted in a 6-dword frame
    push_frame(6, 32'hC000_0000);
    push_exp(6, 32'hC000_0000, 2);
    p0 = pops; d0 = done_cnt; a0 = abort_cnt; c0 = acc_cnt;
    ll_frame_go = 1'b1;
    for (int k = 0; k < 30 && acc_cnt < c0 + 2; k++) tick();
    check("abort_two_accepted", 64'(acc_cnt - c0), 64'd2);
    ll_abort = 1'b1;
    ll_ready = 1'b0;
    tick();
    ll_abort = 1'b0;
    ll_ready = 1'b1;
    check("abort_valid_drop", 64'(ll_valid), 64'd0);
    check("abort_state_drain", 64'(dut.state_q), 64'(ST_DRAIN));
    wait_state(ST_IDLE, 20, "abort_back_idle");
    tick();
    ll_frame_go = 1'b0;
    check("abort_pops", 64'(pops - p0), 64'd6);
    check("abort_pulse", 64'(abort_cnt - a0), 64'd1);
    check("abort_no_done", 64'(done_cnt - d0), 64'd0);
    check("abort_beats", 64'(exp_q.size()), 64'd0);

    // one-dword frame; abort in LAST loses to the accept
    push_frame(1, 32'hDEAD_BEEF);
    push_exp(1, 32'hDEAD_BEEF, 1);
    d0 = done_cnt; a0 = abort_cnt;
    ll_frame_go = 1'b1;
    wait_state(ST_LAST, 20, "one_last");
    ll_abort = 1'b1;
    tick();
    ll_abort = 1'b0;
    ll_frame_go = 1'b0;
    tick();
    check("one_done", 64'(done_cnt - d0), 64'd1);
    check("one_no_abort", 64'(abort_cnt - a0), 64'd0);
    check("one_state", 64'(dut.state_q), 64'(ST_IDLE));
    check("one_beats", 64'(exp_q.size()), 64'd0);

    // abort coinciding with the EOF pop
    push_frame(1, 32'h1111_0000);
    p0 = pops; d0 = done_cnt; a0 = abort_cnt;
    ll_frame_go = 1'b1;
    wait_state(ST_XMIT, 20, "ae_xmit");
    ll_abort = 1'b1;
    tick();
    ll_abort = 1'b0;
    ll_frame_go = 1'b0;
    check("ae_state_idle", 64'(dut.state_q), 64'(ST_IDLE));
    check("ae_valid", 64'(ll_valid), 64'd0);
    check("ae_fifo_empty", 64'(fifo_q.size()), 64'd0);
    tick();
    check("ae_abort", 64'(abort_cnt - a0), 64'd1);
    check("ae_pops", 64'(pops - p0), 64'd1);
    check("ae_no_done", 64'(done_cnt - d0), 64'd0);

    // over-length frame: MAXD+3 dwords
    push_frame(MAXD + 3, 32'h4000_0000);
    push_exp(MAXD + 3, 32'h4000_0000, MAXD - 1);
    p0 = pops; d0 = done_cnt; a0 = abort_cnt; l0 = lerr_cnt;
    ll_frame_go = 1'b1;
    for (int k = 0; k < 3000 && abort_cnt == a0; k++) tick();
    ll_frame_go = 1'b0;
    check("len_err_pulse", 64'(lerr_cnt - l0), 64'd1);
    check("len_err_at_max", 64'(lerr_mark - p0), 64'(MAXD));
    check("len_pops", 64'(pops - p0), 64'(MAXD + 3));
    check("len_abort", 64'(abort_cnt - a0), 64'd1);
    check("len_no_done", 64'(done_cnt - d0), 64'd0);
    check("len_cnt_sat", 64'(dword_cnt), 64'(MAXD));
    check("len_beats", 64'(exp_q.size()), 64'd0);

    // abort during REQ, then the same frame is re-requested and sent
    push_frame(3, 32'h5000_0000);
    p0 = pops; a0 = abort_cnt; d0 = done_cnt;
    for (int k = 0; k < 10 && !ll_frame_req; k++) tick();
    check("req_seen", 64'(ll_frame_req), 64'd1);
    ll_abort = 1'b1;
    tick();
    ll_abort = 1'b0;
    check("req_abort_idle", 64'(dut.state_q), 64'(ST_IDLE));
    tick();
    check("req_abort_pulse", 64'(abort_cnt - a0), 64'd1);
    check("req_abort_no_pop", 64'(pops - p0), 64'd0);
    push_exp(3, 32'h5000_0000, 3);
    ll_frame_go = 1'b1;
    for (int k = 0; k < 30 && done_cnt == d0; k++) tick();
    ll_frame_go = 1'b0;
    check("req_retry_done", 64'(done_cnt - d0), 64'd1);
    check("req_retry_pops", 64'(pops - p0), 64'd3);
    check("req_retry_beats", 64'(exp_q.size()), 64'd0);

    // reset while XMIT holds a stalled dword
    push_frame(4, 32'h6000_0000);
    ll_ready = 1'b0;
    ll_frame_go = 1'b1;
    for (int k = 0; k < 20 && !ll_valid; k++) tick();
    check("rst_pre_valid", 64'(ll_valid), 64'd1);
    rst = 1'b1;
    tick();
    check("rst_mid_outputs",
          64'({ll_frame_req, ll_data, ll_sof, ll_eof, ll_valid, frame_done, frame_aborted, len_err}),
          64'd0);
    check("rst_mid_cnt", 64'(dword_cnt), 64'd0);
    check("rst_mid_state", 64'(dut.state_q), 64'(ST_IDLE));
    check("rst_mid_fifo_kept", 64'(fifo_q.size()), 64'd3);
    rst = 1'b0;
    fifo_q.delete();
    fifo_update();
    ll_frame_go = 1'b0;
    ll_ready = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
